// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver with a first-word-fall-through byte FIFO.
// Raw PS2_CLK/PS2_DAT pins are synchronised, the clock line is glitch
// filtered, 11-bit device-to-host frames are decoded, and good scan-code
// bytes are queued for the game logic. Parity, framing, timeout and
// overflow conditions are reported as status; bad frames are never queued.
module ps2_rx_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 200
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             PS2_CLK,
  input  logic                             PS2_DAT,
  input  logic                             rd_en,
  input  logic                             clr_ovf,
  output logic [7:0]                       rd_data,
  output logic                             rd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fill,
  output logic                             err_parity,
  output logic                             err_frame,
  output logic                             overflow
);

  localparam int TIMEOUT_CYC = (CLK_HZ / 1_000_000) * TIMEOUT_US;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int FILL_W      = $clog2(FIFO_DEPTH + 1);
  localparam int FCNT_W      = $clog2(FILTER_LEN + 1);
  localparam int TCNT_W      = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronisers and clock-line glitch filter
  // ---------------------------------------------------------------------------
  logic [1:0]        clk_sync_q;
  logic [1:0]        dat_sync_q;
  logic              clk_s;
  logic              dat_s;
  logic              filt_q, filt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              fall_q, fall_d;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  // Two-flop synchronisers; idle PS/2 lines are high, so they reset to 1.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours, which is what makes a shift chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples.
  // NOTE: every signal driven here gets a default before any condition, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
        filt_d = clk_s;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  assign fall_d = filt_q & ~filt_d;

  // Filter state and the one-cycle falling-edge strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
      fall_q <= 1'b0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      fall_q <= fall_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame decoder
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [TCNT_W-1:0] tmo_q, tmo_d;
  logic              push;
  logic              perr_d;
  logic              ferr_d;
  logic              parity_ok;

  // Odd parity across the eight data bits plus the received parity bit.
  assign parity_ok = ^{shift_q, par_q};

  // Next-state logic: bit-level transitions on fall, timeout otherwise.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = (state_q == S_IDLE) ? '0 : tmo_q + TCNT_W'(1);
    push      = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    if (fall_q) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!dat_s) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          par_d   = dat_s;
          state_d = S_STOP;
        end
        S_STOP: begin
          push    = parity_ok & dat_s;
          perr_d  = ~parity_ok;
          ferr_d  = ~dat_s;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && tmo_q == TCNT_W'(TIMEOUT_CYC - 1)) begin
      // Device stalled mid-frame: abandon the partial byte.
      state_d = S_IDLE;
      tmo_d   = '0;
      ferr_d  = 1'b1;
    end
  end

  // Decoder registers and registered error pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      err_parity   <= 1'b0;
      err_frame    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      err_parity   <= perr_d;
      err_frame    <= ferr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              overflow_q, overflow_d;
  logic              full;
  logic              do_pop;
  logic              do_push;
  logic              ovf_set;

  assign full    = (fill_q == FILL_W'(FIFO_DEPTH));
  assign do_pop  = rd_en & (fill_q != '0);
  // A simultaneous pop frees the head slot, so a push is accepted even when full.
  assign do_push = push & (~full | do_pop);
  assign ovf_set = push & full & ~do_pop;

  // Occupancy and sticky overflow; a new drop outranks a clear.
  always_comb begin
    fill_d     = fill_q;
    overflow_d = overflow_q;
    case ({do_push, do_pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage.
  // NOTE: the array has no reset; stale contents are unreachable because the
  // head is masked while empty, and a reset-free array maps onto RAM/LUTRAM.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_q] <= shift_q;
    end
  end

  assign rd_valid = (fill_q != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr_q] : 8'h00;
  assign fill     = fill_q;
  assign overflow = overflow_q;

endmodule
